// File: rtl/ix_mult_div_unit.sv
// ----------------------------------------------------------------------------
// ix_mult_div_unit
//
// Iterative multiply/divide unit for the IX stage. It owns the architectural
// HI/LO registers. MULT/MULTU use radix-2 shift-add and DIV/DIVU use a
// restoring divider. Each produces one bit per cycle over 32 iterations,
// followed by a single FIX cycle that applies sign correction and commits.
//
// Ports
//   clk     : pipeline clock; all state updates on its rising edge
//   rst_n   : synchronous, active-low reset
//   start   : launch op on A_in/B_in (accepted in IDLE only)
//   op      : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A_in    : rs value (multiplicand / dividend / MTHI-MTLO data)
//   B_in    : rt value (multiplier / divisor)
//   mthi    : write A_in to HI (accepted in IDLE only)
//   mtlo    : write A_in to LO (accepted in IDLE only)
//   flush   : abort an in-flight operation; HI/LO are left untouched
//   hi_out  : architectural HI
//   lo_out  : architectural LO
//   busy    : operation in flight (stall request)
//   done    : one-cycle pulse when HI/LO are committed
// ----------------------------------------------------------------------------
module ix_mult_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A_in,
    input  logic [XLEN-1:0] B_in,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic            flush,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t              state_reg;
    logic [CW-1:0]       count_reg;
    logic                is_div_reg;
    logic                neg_q_reg;     // product / quotient must be negated
    logic                neg_r_reg;     // remainder must be negated
    logic                div_zero_reg;
    logic [XLEN-1:0]     opnd_reg;      // |A| for multiply, |B| for divide
    logic [XLEN-1:0]     a_raw_reg;     // dividend as issued, for divide-by-zero
    logic [2*XLEN-1:0]   acc_reg;       // {upper, lower} working register
    logic [XLEN-1:0]     hi_reg;
    logic [XLEN-1:0]     lo_reg;
    logic                busy_reg;
    logic                done_reg;

    // Operand preparation at launch. The magnitude of the most negative value
    // falls out of the two's-complement negate as the right unsigned value.
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & A_in[XLEN-1];
    assign b_neg     = is_signed & B_in[XLEN-1];
    assign abs_a     = a_neg ? (~A_in + 1'b1) : A_in;
    assign abs_b     = b_neg ? (~B_in + 1'b1) : B_in;

    // Multiply step: the multiplier sits in the lower half and is consumed
    // LSB first. The partial sum is added into the upper half, then the whole
    // register is shifted right by one.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]}
                    + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    assign mul_next = {mul_sum, acc_reg[XLEN-1:1]};

    // Restoring divide step: the upper half is the remainder and the lower
    // half holds the dividend bits still to be shifted in. Quotient bits
    // enter at the LSB. The shifted remainder needs 33 bits.
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] div_next;

    assign div_trial = acc_reg[2*XLEN-1:XLEN-1] - {1'b0, opnd_reg};
    assign div_next  = div_trial[XLEN]
                     ? {acc_reg[2*XLEN-2:0], 1'b0}
                     : {div_trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};

    // Sign correction applied in FIX.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    assign prod_fix = neg_q_reg ? (~acc_reg + 1'b1) : acc_reg;
    assign quot_fix = neg_q_reg ? (~acc_reg[XLEN-1:0] + 1'b1) : acc_reg[XLEN-1:0];
    assign rem_fix  = neg_r_reg ? (~acc_reg[2*XLEN-1:XLEN] + 1'b1)
                                : acc_reg[2*XLEN-1:XLEN];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            opnd_reg     <= '0;
            a_raw_reg    <= '0;
            acc_reg      <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A move issued alongside start lands now; the later
                    // result overwrites it.
                    if (mthi) hi_reg <= A_in;
                    if (mtlo) lo_reg <= A_in;
                    if (start && !flush) begin
                        state_reg    <= CALC;
                        busy_reg     <= 1'b1;
                        count_reg    <= '0;
                        is_div_reg   <= op[1];
                        neg_q_reg    <= a_neg ^ b_neg;
                        neg_r_reg    <= a_neg;
                        div_zero_reg <= op[1] && (B_in == '0);
                        a_raw_reg    <= A_in;
                        opnd_reg     <= op[1] ? abs_b : abs_a;
                        acc_reg      <= {{XLEN{1'b0}}, (op[1] ? abs_a : abs_b)};
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        acc_reg   <= is_div_reg ? div_next : mul_next;
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == CW'(XLEN - 1)) state_reg <= FIX;
                    end
                end
                FIX: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    if (!flush) begin
                        done_reg <= 1'b1;
                        if (!is_div_reg) begin
                            hi_reg <= prod_fix[2*XLEN-1:XLEN];
                            lo_reg <= prod_fix[XLEN-1:0];
                        end else if (div_zero_reg) begin
                            hi_reg <= a_raw_reg;
                            lo_reg <= '1;
                        end else begin
                            hi_reg <= rem_fix;
                            lo_reg <= quot_fix;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign hi_out = hi_reg;
    assign lo_out = lo_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_ix_mult_div_unit.sv
// ----------------------------------------------------------------------------
// tb_ix_mult_div_unit
//
// Self-checking bench for ix_mult_div_unit. Expected HI/LO values come from a
// plain-arithmetic reference model. Directed corner cases are followed by
// randomized operations, some of which inject an ignored start/mthi/mtlo
// while the unit is busy.
// ----------------------------------------------------------------------------
module tb_ix_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic        mthi;
    logic        mtlo;
    logic        flush;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    ix_mult_div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .A_in   (A_in),
        .B_in   (B_in),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .flush  (flush),
        .hi_out (hi_out),
        .lo_out (lo_out),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model using ordinary integer arithmetic.
    task automatic model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ehi, output logic [31:0] elo);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        logic [63:0]     p;
        sa = a;
        sb = b;
        case (mop)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                p = sp;
                ehi = p[63:32];
                elo = p[31:0];
            end
            2'b01: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                p = up;
                ehi = p[63:32];
                elo = p[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    ehi = a;
                    elo = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    ehi = 32'd0;
                    elo = 32'h8000_0000;
                end else begin
                    ehi = sa % sb;
                    elo = sa / sb;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    ehi = a;
                    elo = 32'hFFFF_FFFF;
                end else begin
                    ehi = a % b;
                    elo = a / b;
                end
            end
        endcase
    endtask

    // Launch one operation and check busy length, done pulse and HI/LO.
    // With inject set, a start/mthi/mtlo with junk data is pulsed mid-flight
    // and must have no effect.
    task automatic run_op(input string tag, input logic [1:0] mop,
                          input logic [31:0] a, input logic [31:0] b, input bit inject);
        logic [31:0] ehi;
        logic [31:0] elo;
        logic [31:0] hi0;
        logic [31:0] lo0;
        int n;
        int early_done;
        model(mop, a, b, ehi, elo);
        hi0 = hi_out;
        lo0 = lo_out;
        op = mop; A_in = a; B_in = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        early_done = 0;
        while (busy && n < 100) begin
            n++;
            if (done) early_done++;
            if (inject && n == 15) begin
                start = 1'b1; op = ~mop; A_in = $urandom; B_in = $urandom;
                mthi = 1'b1; mtlo = 1'b1;
            end else begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            if (n == 20) begin
                chk({tag, "_hi_hold"}, {32'd0, hi_out}, {32'd0, hi0});
                chk({tag, "_lo_hold"}, {32'd0, lo_out}, {32'd0, lo0});
            end
            @(negedge clk);
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
        chk({tag, "_early_done"}, 64'(early_done), 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_hi"}, {32'd0, hi_out}, {32'd0, ehi});
        chk({tag, "_lo"}, {32'd0, lo_out}, {32'd0, elo});
        $display("op=%0d A=0x%08h B=0x%08h -> HI=0x%08h LO=0x%08h busy_cycles=%0d",
                 mop, a, b, hi_out, lo_out, n);
        @(negedge clk);
        chk({tag, "_done_clear"}, {63'd0, done}, 64'd0);
    endtask

    logic [31:0] lo_save;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    int          sel;

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; A_in = '0; B_in = '0;
        mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_hi",   {32'd0, hi_out}, 64'd0);
        chk("rst_lo",   {32'd0, lo_out}, 64'd0);
        chk("rst_busy", {63'd0, busy},   64'd0);
        chk("rst_done", {63'd0, done},   64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases.
        run_op("mult_neg3x5",   2'b00, 32'hFFFF_FFFD, 32'd5,         1'b0);
        run_op("multu_ffxff",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_m1xm1",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div_neg7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,         1'b0);
        run_op("divu_7_2",      2'b11, 32'd7,         32'd2,         1'b0);
        run_op("divu_by0",      2'b11, 32'h0000_1234, 32'd0,         1'b0);
        run_op("div_by0_neg",   2'b10, 32'hFFFF_FF00, 32'd0,         1'b0);
        run_op("div_ovf",       2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_minxmin",  2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1);

        // MTHI in IDLE, visible next cycle.
        A_in = 32'hAAAA_0000; mthi = 1'b1;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_write", {32'd0, hi_out}, 64'h0000_0000_AAAA_0000);
        lo_save = lo_out;

        // MULT 2*3, ignored mtlo at busy cycle 5, flush at busy cycle 10.
        op = 2'b00; A_in = 32'd2; B_in = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            chk("flush_busy_pre", {63'd0, busy}, 64'd1);
            mtlo  = (i == 5);
            A_in  = (i == 5) ? 32'h5555_5555 : 32'd2;
            flush = (i == 10);
            @(negedge clk);
        end
        flush = 1'b0; mtlo = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_done", {63'd0, done}, 64'd0);
        chk("flush_hi",   {32'd0, hi_out}, 64'h0000_0000_AAAA_0000);
        chk("flush_lo",   {32'd0, lo_out}, {32'd0, lo_save});
        for (int i = 0; i < 35; i++) begin
            if (done) chk("flush_late_done", {63'd0, done}, 64'd0);
            @(negedge clk);
        end

        // Flush together with start in IDLE drops the start.
        op = 2'b01; A_in = 32'd9; B_in = 32'd9; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {63'd0, busy}, 64'd0);

        // Reset in the middle of a MULT.
        op = 2'b00; A_in = 32'd1234; B_in = 32'd5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 20; i++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_hi",   {32'd0, hi_out}, 64'd0);
        chk("midrst_lo",   {32'd0, lo_out}, 64'd0);
        chk("midrst_busy", {63'd0, busy},   64'd0);
        chk("midrst_done", {63'd0, done},   64'd0);
        rst_n = 1'b1;
        run_op("post_rst_mult", 2'b00, 32'hFFFF_FF00, 32'd77, 1'b0);

        // Randomized operations, with back-to-back launches.
        for (int k = 0; k < 40; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) rb = 32'($urandom_range(1, 15));
            else if (sel == 2) ra = 32'h8000_0000;
            else if (sel == 3) rb = 32'hFFFF_FFFF;
            run_op($sformatf("rand%0d", k), rop, ra, rb, bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ix_mult_div_unit.md
# ix_mult_div_unit

Iterative multiply/divide unit in the IX stage. It consumes the operand values (A, B) and the mult/div operation decoded upstream and latched by the ID/IX pipeline register. It produces the architectural HI/LO registers for MULT, MULTU, DIV and DIVU, and raises `busy` so the hazard logic stalls IF/ID/IX until the result is committed. It also services MTHI/MTLO writes. MFHI/MFLO reads come straight from `hi_out` and `lo_out`.

## Interface
- `XLEN`, 32: operand width. The design is verified only at 32.
- `clk` in 1: pipeline clock; all state updates on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: launch the operation on `op` using `A_in`/`B_in`. Accepted only in IDLE.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with `start`.
- `A_in` in 32: rs value; multiplicand or dividend.
- `B_in` in 32: rt value; multiplier or divisor.
- `mthi` in 1: write `A_in` to HI. Accepted only in IDLE.
- `mtlo` in 1: write `A_in` to LO. Accepted only in IDLE.
- `flush` in 1: abort any in-flight operation (branch/jump squash).
- `hi_out` out 32: architectural HI.
- `lo_out` out 32: architectural LO.
- `busy` out 1: high while an operation is in flight. Drives the pipeline stall.
- `done` out 1: one-cycle pulse when HI/LO are committed.

## Operation
- Reset (`rst_n`=0 at a posedge): state IDLE, `hi_out`=0, `lo_out`=0, `busy`=0, `done`=0, counter=0. Reset overrides every other input, including an operation in flight.
- States are IDLE, CALC and FIX. `busy` = (state != IDLE), driven from a register.
- IDLE:
  - `start`=1: capture `op`, and |A|, |B| for signed ops (raw values for unsigned). Record the result sign(s). Go to CALC, counter=0.
  - `mthi`/`mtlo` in the same cycle as `start`: the write applies this edge, and the later result overwrites it.
- CALC, multiply: radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle.
- CALC, divide: restoring divide, one quotient bit per cycle. Uses a 33-bit partial remainder for the subtraction.
- CALC exit: counter increments each cycle, and counter==31 goes to FIX.
- FIX: apply sign correction, write HI/LO, pulse `done`, return to IDLE.
- Signed multiply: 64-bit product is negated if the operand signs differ.
- Signed divide: quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
- Commit: HI = product[63:32] or remainder; LO = product[31:0] or quotient.
- Divide by zero (B=0, DIV or DIVU): HI = `A_in`, LO = 0xFFFFFFFF. Full latency applies and `done` still pulses.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Abs of 0x80000000 is taken as unsigned 0x80000000; no special case is needed.
- `start`, `mthi` and `mtlo` while busy are ignored. HI/LO are unchanged and no error is raised.
- `flush`=1 in CALC or FIX: return to IDLE next edge, HI/LO unchanged, no `done`.
- `flush` in IDLE is a no-op. `flush` together with `start` in IDLE: the flush wins and the start is dropped.

## Timing
- `start` is sampled at edge N.
  - `busy`=1 from after edge N.
  - Iterations occur at edges N+1 … N+32.
  - FIX commits at edge N+33. After N+33: `busy`=0, `done`=1 for exactly one cycle, `hi_out`/`lo_out` hold the new values.
- `busy` is high for 33 cycles for every op, including divide by zero.
- Back-to-back: a new `start` is accepted at edge N+33+1, the first IDLE edge.
- MTHI/MTLO: written at the accepting edge, visible on outputs the next cycle. There is no bypass of `A_in` to the outputs.
- `hi_out`/`lo_out` change only at reset, FIX, or an accepted MTHI/MTLO.

## Test plan
- Reset, then MULT A=0xFFFFFFFD (-3), B=5 -> after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1, `done` pulses once.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Repeat as MULT -> HI=0, LO=1.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
- DIVU A=0x1234, B=0 -> HI=0x1234, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xAAAA0000 in IDLE, then MULT 2*3 with `flush` asserted at busy cycle 10 -> `busy` drops next edge, no `done`, HI=0xAAAA0000, LO unchanged. A `mtlo` issued during busy is ignored.
- MULT in flight, `rst_n`=0 at busy cycle 20 -> all outputs 0 next edge. A `start` on the first cycle after reset releases is accepted normally.
